// File: rtl/combo_lock_pkg.sv
// Shared types and defaults for the keypad combination-lock controller.
package combo_lock_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StUnlocked,
    StProg,
    StLockout
  } state_e;

  localparam int unsigned DefDigitW        = 4;
  localparam int unsigned DefNumDigits     = 4;
  localparam int unsigned DefMaxTries      = 3;
  localparam int unsigned DefLockoutCycles = 1000;
  localparam logic [15:0] DefInitCode      = 16'h0000;
  localparam logic [15:0] DefMasterCode    = 16'hBC00;

  // Total width of a full code entry.
  function automatic int unsigned code_width(input int unsigned digit_w,
                                             input int unsigned num_digits);
    return digit_w * num_digits;
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// Down-counter that times the lockout dwell. start loads CYCLES-1, so
// expired first rises exactly CYCLES-1 cycles after the load; clear aborts.
module lockout_timer #(
  parameter int unsigned CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int unsigned TW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [TW-1:0] count_q;

  // Load on start, then count down and hold at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= TW'(CYCLES - 1);
    end else if (count_q != '0) begin
      count_q <= count_q - TW'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/combo_lock_ctrl.sv
// Keypad combination-lock controller: N-digit entry compare against a
// programmable code, failed-attempt counting and a timed lockout.
// Optional feature macro: COMBO_LOCK_MASTER_UNLOCK_EN (master code accepted
// in IDLE and able to break a lockout).
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int unsigned DIGIT_W        = DefDigitW,
  parameter int unsigned NUM_DIGITS     = DefNumDigits,
  parameter int unsigned MAX_TRIES      = DefMaxTries,
  parameter int unsigned LOCKOUT_CYCLES = DefLockoutCycles,
  parameter logic [code_width(DIGIT_W, NUM_DIGITS)-1:0] INIT_CODE   = DefInitCode,
  parameter logic [code_width(DIGIT_W, NUM_DIGITS)-1:0] MASTER_CODE = DefMasterCode
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              digit_valid,
  input  logic [DIGIT_W-1:0]                digit,
  input  logic                              lock_req,
  input  logic                              prog_req,
  output logic                              unlocked,
  output logic                              locked_out,
  output logic                              prog_active,
  output logic [$clog2(MAX_TRIES+1)-1:0]    fail_cnt,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   entry_cnt
);

  localparam int unsigned CW = code_width(DIGIT_W, NUM_DIGITS);
  localparam int unsigned FW = $clog2(MAX_TRIES + 1);
  localparam int unsigned EW = $clog2(NUM_DIGITS + 1);

  state_e              state_q;
  logic [CW-1:0]       code_q;
  logic [CW-1:0]       entry_q;
  logic [CW-1:0]       shadow_q;
  logic [CW+DIGIT_W-1:0] entry_cat;
  logic [CW+DIGIT_W-1:0] shadow_cat;
  logic [CW-1:0]       entry_next;
  logic [CW-1:0]       shadow_next;
  logic [FW-1:0]       fail_inc;
  logic                last_digit;
  logic                entry_match;
  logic                fail_limit;
  logic                timer_start;
  logic                timer_clear;
  logic                timer_expired;
`ifdef COMBO_LOCK_MASTER_UNLOCK_EN
  logic                master_hit;
`endif

  // Shift-in values, completion and compare decode shared by the FSM and timer.
  always_comb begin
    // Dropping the top digit of the concatenation is the shift; first digit ends in MSBs.
    entry_cat   = {entry_q, digit};
    shadow_cat  = {shadow_q, digit};
    entry_next  = entry_cat[CW-1:0];
    shadow_next = shadow_cat[CW-1:0];
    last_digit  = (entry_cnt == EW'(NUM_DIGITS - 1));
    fail_inc    = fail_cnt + FW'(1);
    fail_limit  = (fail_inc == FW'(MAX_TRIES));
`ifdef COMBO_LOCK_MASTER_UNLOCK_EN
    master_hit  = (entry_next == MASTER_CODE);
    entry_match = (entry_next == code_q) || master_hit;
    timer_clear = (state_q == StLockout) && digit_valid && last_digit && master_hit;
`else
    entry_match = (entry_next == code_q);
    timer_clear = 1'b0;
`endif
    timer_start = (state_q == StIdle) && digit_valid && last_digit && !entry_match &&
                  fail_limit;
  end

  lockout_timer #(
    .CYCLES (LOCKOUT_CYCLES)
  ) u_lockout_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (timer_start),
    .clear   (timer_clear),
    .expired (timer_expired)
  );

  // Main FSM with registered outputs, entry/shadow buffers and fail counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      code_q      <= INIT_CODE;
      entry_q     <= '0;
      shadow_q    <= '0;
      unlocked    <= 1'b0;
      locked_out  <= 1'b0;
      prog_active <= 1'b0;
      fail_cnt    <= '0;
      entry_cnt   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (digit_valid) begin
            if (last_digit) begin
              entry_q   <= '0;
              entry_cnt <= '0;
              if (entry_match) begin
                state_q  <= StUnlocked;
                unlocked <= 1'b1;
                fail_cnt <= '0;
              end else begin
                fail_cnt <= fail_inc;
                if (fail_limit) begin
                  state_q    <= StLockout;
                  locked_out <= 1'b1;
                end
              end
            end else begin
              entry_q   <= entry_next;
              entry_cnt <= entry_cnt + EW'(1);
            end
          end
        end

        StUnlocked: begin
          if (lock_req) begin
            state_q  <= StIdle;
            unlocked <= 1'b0;
          end else if (prog_req) begin
            state_q     <= StProg;
            prog_active <= 1'b1;
            shadow_q    <= '0;
            entry_cnt   <= '0;
          end
        end

        StProg: begin
          // lock_req outranks a same-cycle digit; the code is left untouched.
          if (lock_req) begin
            state_q     <= StIdle;
            unlocked    <= 1'b0;
            prog_active <= 1'b0;
            shadow_q    <= '0;
            entry_cnt   <= '0;
          end else if (digit_valid) begin
            if (last_digit) begin
              code_q      <= shadow_next;
              shadow_q    <= '0;
              entry_cnt   <= '0;
              state_q     <= StUnlocked;
              prog_active <= 1'b0;
            end else begin
              shadow_q  <= shadow_next;
              entry_cnt <= entry_cnt + EW'(1);
            end
          end
        end

        StLockout: begin
`ifdef COMBO_LOCK_MASTER_UNLOCK_EN
          if (timer_clear) begin
            state_q    <= StUnlocked;
            unlocked   <= 1'b1;
            locked_out <= 1'b0;
            fail_cnt   <= '0;
            entry_q    <= '0;
            entry_cnt  <= '0;
          end else if (timer_expired) begin
            state_q    <= StIdle;
            locked_out <= 1'b0;
            fail_cnt   <= '0;
            entry_q    <= '0;
            entry_cnt  <= '0;
          end else if (digit_valid) begin
            // A complete non-master entry is simply discarded.
            if (last_digit) begin
              entry_q   <= '0;
              entry_cnt <= '0;
            end else begin
              entry_q   <= entry_next;
              entry_cnt <= entry_cnt + EW'(1);
            end
          end
`else
          if (timer_expired) begin
            state_q    <= StIdle;
            locked_out <= 1'b0;
            fail_cnt   <= '0;
          end
`endif
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed self-checking bench for combo_lock_ctrl (INIT_CODE = 16'h1234).
module tb_combo_lock_ctrl;

  localparam int unsigned LockCycles = 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       digit_valid;
  logic [3:0] digit;
  logic       lock_req;
  logic       prog_req;
  logic       unlocked;
  logic       locked_out;
  logic       prog_active;
  logic [1:0] fail_cnt;
  logic [2:0] entry_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_lock;

  always #5 clk = ~clk;

  combo_lock_ctrl #(
    .INIT_CODE (16'h1234)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .digit_valid (digit_valid),
    .digit       (digit),
    .lock_req    (lock_req),
    .prog_req    (prog_req),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .prog_active (prog_active),
    .fail_cnt    (fail_cnt),
    .entry_cnt   (entry_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int ul, input int lo, input int pa,
                            input int fc, input int ec);
    check({tag, ".unlocked"}, int'(unlocked), ul);
    check({tag, ".locked_out"}, int'(locked_out), lo);
    check({tag, ".prog_active"}, int'(prog_active), pa);
    check({tag, ".fail_cnt"}, int'(fail_cnt), fc);
    check({tag, ".entry_cnt"}, int'(entry_cnt), ec);
  endtask

  // One-cycle digit strobe; returns on the negedge after the sampling edge.
  task automatic press(input logic [3:0] d);
    @(negedge clk);
    digit_valid = 1'b1;
    digit       = d;
    @(negedge clk);
    digit_valid = 1'b0;
  endtask

  task automatic enter(input logic [15:0] code);
    for (int i = 0; i < 4; i++) press(code[15-4*i -: 4]);
  endtask

  task automatic pulse_lock();
    @(negedge clk);
    lock_req = 1'b1;
    @(negedge clk);
    lock_req = 1'b0;
  endtask

  task automatic pulse_prog();
    @(negedge clk);
    prog_req = 1'b1;
    @(negedge clk);
    prog_req = 1'b0;
  endtask

  // Asynchronous reset pulse; outputs must clear without waiting for a clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outs(tag, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Counts cycles with locked_out high, starting from a negedge where it is already high.
  // Optionally keys in B,C,0,0 during the first eight cycles.
  task automatic count_lockout(input bit send_master, output int n);
    logic [15:0] m;
    m = 16'hBC00;
    n = 1;
    for (int k = 0; k < 2 * LockCycles; k++) begin
      @(negedge clk);
      if (!locked_out) break;
      n++;
      if (send_master && k < 8) begin
        digit_valid = (k % 2 == 0);
        digit       = m[15-4*(k/2) -: 4];
      end
    end
    digit_valid = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    digit_valid = 1'b0;
    digit       = '0;
    lock_req    = 1'b0;
    prog_req    = 1'b0;
    repeat (2) @(negedge clk);
    check_outs("rst", 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Correct code unlocks the cycle after the 4th strobe.
    press(4'h1); press(4'h2); press(4'h3);
    check_outs("partial", 0, 0, 0, 0, 3);
    press(4'h4);
    check_outs("unlock", 1, 0, 0, 0, 0);
    pulse_lock();
    check_outs("relock", 0, 0, 0, 0, 0);

    // Three mismatches: fail counter steps, then a full-length lockout.
    enter(16'h1235);
    check_outs("miss1", 0, 0, 0, 1, 0);
    enter(16'h1235);
    check_outs("miss2", 0, 0, 0, 2, 0);
    enter(16'h1235);
    check_outs("miss3", 0, 1, 0, 3, 0);
    count_lockout(1'b0, n_lock);
    check("lockout_len", n_lock, 1000);
    check_outs("after_lockout", 0, 0, 0, 0, 0);
    enter(16'h1234);
    check("unlock_after_lockout", int'(unlocked), 1);

    // lock_req beats a simultaneous prog_req.
    @(negedge clk);
    lock_req = 1'b1;
    prog_req = 1'b1;
    @(negedge clk);
    lock_req = 1'b0;
    prog_req = 1'b0;
    check_outs("lock_vs_prog", 0, 0, 0, 0, 0);

    // Program 9876, then only the new code opens.
    enter(16'h1234);
    pulse_prog();
    check_outs("prog_enter", 1, 0, 1, 0, 0);
    press(4'h9); press(4'h8);
    check_outs("prog_2dig", 1, 0, 1, 0, 2);
    press(4'h7); press(4'h6);
    check_outs("prog_done", 1, 0, 0, 0, 0);
    pulse_lock();
    enter(16'h1234);
    check_outs("old_code", 0, 0, 0, 1, 0);
    enter(16'h9876);
    check_outs("new_code", 1, 0, 0, 0, 0);
    pulse_lock();

    // Reset restores INIT_CODE.
    do_reset("rst_after_prog");
    enter(16'h9876);
    check("prog_volatile", int'(unlocked), 0);
    enter(16'h1234);
    check("init_restored", int'(unlocked), 1);

    // lock_req with a digit after two PROG digits aborts and keeps the code.
    pulse_prog();
    press(4'h5); press(4'h5);
    @(negedge clk);
    lock_req    = 1'b1;
    digit_valid = 1'b1;
    digit       = 4'h5;
    @(negedge clk);
    lock_req    = 1'b0;
    digit_valid = 1'b0;
    check_outs("prog_abort", 0, 0, 0, 0, 0);
    enter(16'h1234);
    check("code_kept", int'(unlocked), 1);
    pulse_lock();

    // Reset mid-entry clears the partial entry.
    press(4'h1); press(4'h2);
    check("mid_entry_cnt", int'(entry_cnt), 2);
    do_reset("rst_mid_entry");
    enter(16'h1234);
    check_outs("unlock_after_rst", 1, 0, 0, 0, 0);
    pulse_lock();

    // Reset during LOCKOUT.
    enter(16'h0000); enter(16'h0000); enter(16'h0000);
    check("lockout_again", int'(locked_out), 1);
    repeat (10) @(negedge clk);
    do_reset("rst_in_lockout");
    enter(16'h1234);
    check_outs("unlock_after_lo_rst", 1, 0, 0, 0, 0);
    pulse_lock();

    // Master code keyed during LOCKOUT.
    enter(16'h1111); enter(16'h1111); enter(16'h1111);
    check("lockout_master", int'(locked_out), 1);
    count_lockout(1'b1, n_lock);
`ifdef COMBO_LOCK_MASTER_UNLOCK_EN
    check("master_len", n_lock, 8);
    check_outs("master_unlock", 1, 0, 0, 0, 0);
    pulse_lock();
`else
    check("master_ignored_len", n_lock, 1000);
    check_outs("master_ignored", 0, 0, 0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
